data_mem_bridge: RTL and testbench

//  Sits between the MEM stage and the data-memory bus; consumes the MEM-stage request (addr, wdata, size, rd/wr enables).

---
 rtl/data_mem_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge
// Brief    : MEM-stage to data-memory bus bridge (req/gnt + rvalid) with byte
//            strobes, store replication, load alignment and a timeout.
//            Optional build macro: DMEM_MISALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr,
    input  logic [1:0]  i_data_size,
    input  logic        i_data_rd_en,
    input  logic        i_data_wr_en,
    output logic [31:0] o_data_rd,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] C_TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic                     bus_req_q, bus_req_d;
    logic                     bus_we_q, bus_we_d;
    logic [31:0]              bus_addr_q, bus_addr_d;
    logic [31:0]              bus_wdata_q, bus_wdata_d;
    logic [3:0]               bus_be_q, bus_be_d;
    logic [31:0]              data_rd_q, data_rd_d;
    logic                     bus_err_q, bus_err_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]               size_q, size_d;
    logic [1:0]               off_q, off_d;

    logic        req_any;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shift;
    logic [31:0] rd_aligned;
    logic        timeout;

    assign req_any = i_data_rd_en | i_data_wr_en;
    assign timeout = (cnt_q == C_TO_LAST);

    // Size 2'b11 behaves exactly like a word access.
    always_comb begin
        req_off   = 2'b00;
        req_be    = 4'b1111;
        req_wdata = i_data_wr;
        case (i_data_size)
            2'b00: begin
                req_off   = i_data_addr[1:0];
                req_be    = 4'b0001 << i_data_addr[1:0];
                req_wdata = {4{i_data_wr[7:0]}};
            end
            2'b01: begin
                req_off   = {i_data_addr[1], 1'b0};
                req_be    = 4'b0011 << {i_data_addr[1], 1'b0};
                req_wdata = {2{i_data_wr[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((i_data_size == 2'b01) && i_data_addr[0]) ||
                      (i_data_size[1] && (i_data_addr[1:0] != 2'b00));
`endif

    // Addressed byte/half lands at bit 0; bits above the access size are zero.
    assign rd_shift = i_bus_rdata >> {off_q, 3'b000};
    always_comb begin
        case (size_q)
            2'b00:   rd_aligned = {24'd0, rd_shift[7:0]};
            2'b01:   rd_aligned = {16'd0, rd_shift[15:0]};
            default: rd_aligned = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        data_rd_d   = data_rd_q;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
        size_d      = size_q;
        off_d       = off_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
`ifdef DMEM_MISALIGN_CHECK_EN
                    if (misalign) begin
                        state_d   = S_DONE;
                        bus_err_d = 1'b1;
                        data_rd_d = 32'd0;
                    end else
`endif
                    begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = i_data_wr_en;
                        bus_addr_d  = {i_data_addr[31:2], 2'b00};
                        bus_wdata_d = req_wdata;
                        bus_be_d    = req_be;
                        size_d      = i_data_size;
                        off_d       = req_off;
                        cnt_d       = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                if (i_bus_gnt && i_bus_rvalid) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) data_rd_d = rd_aligned;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    data_rd_d = 32'd0;
                end else if (i_bus_gnt) begin
                    state_d   = S_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                if (i_bus_rvalid) begin
                    state_d = S_DONE;
                    if (!bus_we_q) data_rd_d = rd_aligned;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    data_rd_d = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            data_rd_q   <= 32'd0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            data_rd_q   <= data_rd_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            off_q       <= off_d;
        end
    end

    assign o_stall     = req_any && (state_q != S_DONE);
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_be    = bus_be_q;
    assign o_data_rd   = data_rd_q;
    assign o_bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_bridge
// Brief    : Directed self-checking bench for data_mem_bridge.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [1:0]  data_size;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] data_rd;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    data_mem_bridge #(
        .TIMEOUT_CYCLES (255),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_addr  (data_addr),
        .i_data_wr    (data_wr),
        .i_data_size  (data_size),
        .i_data_rd_en (rd_en),
        .i_data_wr_en (wr_en),
        .o_data_rd    (data_rd),
        .o_stall      (stall),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_be     (bus_be),
        .i_bus_gnt    (bus_gnt),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata),
        .o_bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Single access granted and answered in the same cycle.
    task automatic access(input string tag, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rd);
        data_addr = addr;
        data_wr   = wd;
        data_size = sz;
        rd_en     = !we;
        wr_en     = we;
        #1 chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk({tag, "_req"},   {31'd0, bus_req}, 32'd1);
        chk({tag, "_addr"},  bus_addr, exp_addr);
        chk({tag, "_be"},    {28'd0, bus_be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, bus_wdata, exp_wdata);
        chk({tag, "_we"},    {31'd0, bus_we}, {31'd0, we});
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(negedge clk);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req_done"},   {31'd0, bus_req}, 32'd0);
        chk({tag, "_rd"},         data_rd, exp_rd);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        data_addr  = 32'd0;
        data_wr    = 32'd0;
        data_size  = 2'b00;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_we",    {31'd0, bus_we}, 32'd0);
        chk("rst_addr",  bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_be",    {28'd0, bus_be}, 32'd0);
        chk("rst_rd",    data_rd, 32'd0);
        chk("rst_err",   {31'd0, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100: gnt one cycle, rvalid the next; stall held three cycles
        data_addr = 32'h0000_0100;
        data_size = 2'b10;
        rd_en     = 1'b1;
        #1 chk("lw_stall_c0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("lw_stall_c1", {31'd0, stall}, 32'd1);
        chk("lw_req",      {31'd0, bus_req}, 32'd1);
        chk("lw_addr",     bus_addr, 32'h0000_0100);
        chk("lw_be",       {28'd0, bus_be}, 32'h0000_000F);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("lw_stall_c2", {31'd0, stall}, 32'd1);
        chk("lw_req_wait", {31'd0, bus_req}, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("lw_stall_c3", {31'd0, stall}, 32'd0);
        chk("lw_rd",       data_rd, 32'hDEAD_BEEF);
        chk("lw_err",      {31'd0, bus_err}, 32'd0);
        rd_en = 1'b0;
        @(negedge clk);

        // Stores leave o_data_rd untouched even though rvalid carries data
        access("sb", 1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h1111_1111,
               32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        access("sh", 1'b1, 2'b01, 32'h0000_0406, 32'h1234_BEEF, 32'h2222_2222,
               32'h0000_0404, 4'b1100, 32'hBEEF_BEEF, 32'hDEAD_BEEF);
        access("lh", 1'b0, 2'b01, 32'h0000_0402, 32'h0000_0000, 32'h8001_1234,
               32'h0000_0400, 4'b1100, 32'h0000_0000, 32'h0000_8001);
        access("lb", 1'b0, 2'b00, 32'h0000_0401, 32'h0000_0000, 32'h8001_1234,
               32'h0000_0400, 4'b0010, 32'h0000_0000, 32'h0000_0012);
        access("sw11", 1'b1, 2'b11, 32'h0000_0300, 32'hCAFE_F00D, 32'h3333_3333,
               32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0000_0012);

        // Timeout: gnt never arrives; 255 cycles in REQ
        data_addr = 32'h0000_0500;
        data_size = 2'b10;
        rd_en     = 1'b1;
        @(negedge clk);
        chk("to_req_first", {31'd0, bus_req}, 32'd1);
        for (int i = 0; i < 254; i++) @(negedge clk);
        chk("to_req_last",  {31'd0, bus_req}, 32'd1);
        chk("to_err_early", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        chk("to_err",   {31'd0, bus_err}, 32'd1);
        chk("to_req",   {31'd0, bus_req}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        chk("to_rd",    data_rd, 32'd0);
        rd_en      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("to_err_pulse", {31'd0, bus_err}, 32'd0);
        chk("to_late_rd",   data_rd, 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("to_late_rd2", data_rd, 32'd0);
        chk("to_late_req", {31'd0, bus_req}, 32'd0);

        // Misaligned word access
`ifdef DMEM_MISALIGN_CHECK_EN
        data_addr = 32'h0000_0102;
        data_size = 2'b10;
        rd_en     = 1'b1;
        #1 chk("mis_stall_c0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("mis_req",   {31'd0, bus_req}, 32'd0);
        chk("mis_err",   {31'd0, bus_err}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_rd",    data_rd, 32'd0);
        rd_en = 1'b0;
        @(negedge clk);
`else
        access("lw_mis", 1'b0, 2'b10, 32'h0000_0102, 32'h0000_0000, 32'h1122_3344,
               32'h0000_0100, 4'b1111, 32'h0000_0000, 32'h1122_3344);
`endif

        // Reset during WAIT_RSP, then a stray response
        data_addr = 32'h0000_0600;
        data_size = 2'b10;
        rd_en     = 1'b1;
        @(negedge clk);
        chk("mr_req", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("mr_stall_wait", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("mr_rst_addr", bus_addr, 32'd0);
        chk("mr_rst_be",   {28'd0, bus_be}, 32'd0);
        chk("mr_rst_rd",   data_rd, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hAAAA_5555;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("mr_rd",    data_rd, 32'd0);
        chk("mr_req0",  {31'd0, bus_req}, 32'd0);
        chk("mr_stall", {31'd0, stall}, 32'd0);
        // A fresh request is taken immediately, proving the FSM sits in IDLE
        data_addr = 32'h0000_0700;
        data_size = 2'b00;
        rd_en     = 1'b1;
        @(negedge clk);
        chk("mr_new_req", {31'd0, bus_req}, 32'd1);
        chk("mr_new_be",  {28'd0, bus_be}, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
